fwd_hazard_unit: RTL and testbench

//  Parametrised forwarding and hazard unit for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_match.sv | 15 +
 rtl/fwd_hazard_unit.sv | 139 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand-mux select codes and the
// control half of an in-flight pipeline slot.
package fwd_pkg;

    // Operand-mux select codes, one 2-bit field per source operand.
    localparam logic [1:0] FWD_RF  = 2'b00;  // value from the register file
    localparam logic [1:0] FWD_MEM = 2'b10;  // value from the EX/MEM register
    localparam logic [1:0] FWD_WB  = 2'b01;  // value from the MEM/WB register

    // Control bits of a slot; the destination index is added by the top, whose width
    // depends on REG_AW.
    typedef struct packed {
        logic vld;
        logic regwrite;
        logic memread;
    } slot_ctrl_t;

endpackage

// File: rtl/fwd_match.sv
// Hit compare between one tracked pipeline slot and one source register index.
// Index 0 is the hardwired zero register and never hits.
module fwd_match #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              slotVld_i,
    input  logic              slotRegwrite_i,
    input  logic [REG_AW-1:0] slotRd_i,
    input  logic [REG_AW-1:0] src_i,
    output logic              hit_o
);

    assign hit_o = slotVld_i & slotRegwrite_i & (slotRd_i == src_i) & (src_i != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for a 5-stage pipeline. Tracks the destinations of the
// instructions in EX, MEM and WB, drives the EX operand-mux selects, raises load-use
// (or, without forwarding, any-RAW) stalls and counts stall cycles.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_AW  = 5,
    parameter bit          FWD_EN  = 1'b1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic                      flush,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_count
);

    typedef struct packed {
        slot_ctrl_t        ctrl;
        logic [REG_AW-1:0] rd;
    } slot_t;

    slot_t exQ, memQ, wbQ, exD;
    logic [CNT_W-1:0] stallCntQ;

    // Hits of each slot against the ID sources (stall) and the EX sources (forwarding).
    logic [NUM_SRC-1:0] exHitId, memHitId, wbHitId, memHitEx, wbHitEx;

    // The WB load flag is carried for completeness but nothing downstream needs it.
    logic unusedWbMemread;
    assign unusedWbMemread = wbQ.ctrl.memread;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_match #(.REG_AW(REG_AW)) uExId (
            .slotVld_i     (exQ.ctrl.vld),
            .slotRegwrite_i(exQ.ctrl.regwrite),
            .slotRd_i      (exQ.rd),
            .src_i         (id_rs[k*REG_AW +: REG_AW]),
            .hit_o         (exHitId[k])
        );
        fwd_match #(.REG_AW(REG_AW)) uMemId (
            .slotVld_i     (memQ.ctrl.vld),
            .slotRegwrite_i(memQ.ctrl.regwrite),
            .slotRd_i      (memQ.rd),
            .src_i         (id_rs[k*REG_AW +: REG_AW]),
            .hit_o         (memHitId[k])
        );
        fwd_match #(.REG_AW(REG_AW)) uWbId (
            .slotVld_i     (wbQ.ctrl.vld),
            .slotRegwrite_i(wbQ.ctrl.regwrite),
            .slotRd_i      (wbQ.rd),
            .src_i         (id_rs[k*REG_AW +: REG_AW]),
            .hit_o         (wbHitId[k])
        );
        fwd_match #(.REG_AW(REG_AW)) uMemEx (
            .slotVld_i     (memQ.ctrl.vld),
            .slotRegwrite_i(memQ.ctrl.regwrite),
            .slotRd_i      (memQ.rd),
            .src_i         (ex_rs[k*REG_AW +: REG_AW]),
            .hit_o         (memHitEx[k])
        );
        fwd_match #(.REG_AW(REG_AW)) uWbEx (
            .slotVld_i     (wbQ.ctrl.vld),
            .slotRegwrite_i(wbQ.ctrl.regwrite),
            .slotRd_i      (wbQ.rd),
            .src_i         (ex_rs[k*REG_AW +: REG_AW]),
            .hit_o         (wbHitEx[k])
        );
    end

    // Stall: load-use with forwarding, any outstanding RAW without it; quiet in reset.
    always_comb begin
        stall = 1'b0;
        if (rst && id_valid) begin
            if (FWD_EN) begin
                stall = exQ.ctrl.memread & (|exHitId);
            end else begin
                stall = |{exHitId, memHitId, wbHitId};
            end
        end
    end

    // Operand selects: MEM (youngest) beats WB, otherwise the register file.
    always_comb begin
        fwd_sel = '0;
        if (rst && FWD_EN) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (memHitEx[k]) begin
                    fwd_sel[k*2 +: 2] = FWD_MEM;
                end else if (wbHitEx[k]) begin
                    fwd_sel[k*2 +: 2] = FWD_WB;
                end else begin
                    fwd_sel[k*2 +: 2] = FWD_RF;
                end
            end
        end
    end

    // Next EX slot: stall or flush turns the instruction leaving ID into a bubble.
    always_comb begin
        exD.ctrl.vld      = id_valid & ~stall & ~flush;
        exD.ctrl.regwrite = id_regwrite;
        exD.ctrl.memread  = id_memread;
        exD.rd            = id_rd;
    end

    // Slot shift register tracking the instructions in EX, MEM and WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exQ  <= '0;
            memQ <= '0;
            wbQ  <= '0;
        end else begin
            wbQ  <= memQ;
            memQ <= exQ;
            exQ  <= exD;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCntQ <= '0;
        end else if (stall && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + 1'b1;
        end
    end

    assign stall_count = stallCntQ;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: one instance with forwarding (CNT_W=16) and one without forwarding
// using a 2-bit stall counter to reach saturation.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Instance A: FWD_EN=1
    logic        idValid = 1'b0;
    logic [9:0]  idRs = '0;
    logic [4:0]  idRd = '0;
    logic        idRegwrite = 1'b0;
    logic        idMemread = 1'b0;
    logic [9:0]  exRs = '0;
    logic        flush = 1'b0;
    logic [3:0]  fwdSel;
    logic        stall;
    logic [15:0] stallCount;

    // Instance B: FWD_EN=0, CNT_W=2
    logic        bValid = 1'b0;
    logic [9:0]  bRs = '0;
    logic [4:0]  bRd = '0;
    logic        bRegwrite = 1'b0;
    logic        bMemread = 1'b0;
    logic [9:0]  bExRs = '0;
    logic        bFlush = 1'b0;
    logic [3:0]  bFwdSel;
    logic        bStall;
    logic [1:0]  bCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) dutA (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (idValid),
        .id_rs      (idRs),
        .id_rd      (idRd),
        .id_regwrite(idRegwrite),
        .id_memread (idMemread),
        .ex_rs      (exRs),
        .flush      (flush),
        .fwd_sel    (fwdSel),
        .stall      (stall),
        .stall_count(stallCount)
    );

    fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .FWD_EN(1'b0), .CNT_W(2)) dutB (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (bValid),
        .id_rs      (bRs),
        .id_rd      (bRd),
        .id_regwrite(bRegwrite),
        .id_memread (bMemread),
        .ex_rs      (bExRs),
        .flush      (bFlush),
        .fwd_sel    (bFwdSel),
        .stall      (bStall),
        .stall_count(bCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a would-be hit presented on both ID and EX sources.
        idValid = 1'b1; idRs = 10'd5; exRs = 10'd5; idRd = 5'd5; idRegwrite = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fwd_sel", 32'(fwdSel), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_count", 32'(stallCount), 32'h0);
        chk("rst_count_b", 32'(bCount), 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_fwd_sel", 32'(fwdSel), 32'h0);
        chk("rel_stall", 32'(stall), 32'h0);
        idValid = 1'b0; idRegwrite = 1'b0; idRs = '0; exRs = '0;
        tick(); tick(); tick();

        // EX/MEM then MEM/WB forwarding of an ALU result on rs1.
        idValid = 1'b1; idRd = 5'd5; idRegwrite = 1'b1; idMemread = 1'b0; idRs = '0;
        tick();
        idRs = 10'd5; idRd = 5'd6; idRegwrite = 1'b0;
        #1;
        chk("alu_no_stall", 32'(stall), 32'h0);
        tick();
        idValid = 1'b0; exRs = 10'd5;
        #1;
        chk("fwd_mem", 32'(fwdSel), 32'h2);
        tick();
        chk("fwd_wb", 32'(fwdSel), 32'h1);
        tick();
        chk("fwd_drained", 32'(fwdSel), 32'h0);
        exRs = '0; idRs = '0;

        // Back-to-back writers of x7: MEM copy wins over WB copy on both operands.
        idValid = 1'b1; idRd = 5'd7; idRegwrite = 1'b1;
        tick();
        tick();
        idValid = 1'b0;
        tick();
        exRs = {5'd7, 5'd7};
        #1;
        chk("prio_mem_over_wb", 32'(fwdSel), 32'ha);
        tick();
        chk("prio_wb_next", 32'(fwdSel), 32'h5);
        tick();
        exRs = '0;

        // Load-use: one stall, load in MEM not stalled, then MEM/WB forward.
        idValid = 1'b1; idRd = 5'd3; idRegwrite = 1'b1; idMemread = 1'b1; idRs = '0;
        tick();
        idRd = 5'd8; idRegwrite = 1'b0; idMemread = 1'b0; idRs = 10'd3;
        #1;
        chk("load_use_stall", 32'(stall), 32'h1);
        tick();
        chk("load_in_mem_no_stall", 32'(stall), 32'h0);
        chk("stall_count_1", 32'(stallCount), 32'h1);
        tick();
        idValid = 1'b0; idRs = '0; exRs = 10'd3;
        #1;
        chk("load_fwd_wb", 32'(fwdSel), 32'h1);
        tick(); tick(); tick();
        exRs = '0;

        // Load into x0: neither stall nor forward on index 0.
        idValid = 1'b1; idRd = 5'd0; idRegwrite = 1'b1; idMemread = 1'b1; idRs = '0;
        tick();
        idRd = 5'd8; idRegwrite = 1'b0; idMemread = 1'b0; idRs = '0;
        #1;
        chk("x0_no_stall", 32'(stall), 32'h0);
        tick();
        idValid = 1'b0; exRs = '0;
        #1;
        chk("x0_no_fwd", 32'(fwdSel), 32'h0);
        tick(); tick(); tick();

        // Flushed load leaves a bubble, so a dependent instruction does not stall.
        idValid = 1'b1; idRd = 5'd4; idRegwrite = 1'b1; idMemread = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; idRd = 5'd8; idRegwrite = 1'b0; idMemread = 1'b0; idRs = 10'd4;
        #1;
        chk("flush_bubble", 32'(stall), 32'h0);
        tick();
        idValid = 1'b0; idRs = '0;
        tick(); tick(); tick();

        // Flush and load-use together: stall still reported and counted.
        idValid = 1'b1; idRd = 5'd3; idRegwrite = 1'b1; idMemread = 1'b1;
        tick();
        idRd = 5'd8; idRegwrite = 1'b0; idMemread = 1'b0; idRs = {5'd3, 5'd0}; flush = 1'b1;
        #1;
        chk("flush_with_stall", 32'(stall), 32'h1);
        tick();
        flush = 1'b0; idValid = 1'b0; idRs = '0;
        #1;
        chk("stall_count_2", 32'(stallCount), 32'h2);
        tick(); tick(); tick();

        // No-forwarding instance: RAW stalls across EX, MEM, WB and counter saturation.
        bValid = 1'b1; bRd = 5'd9; bRegwrite = 1'b1; bRs = '0;
        tick();
        bRd = 5'd10; bRegwrite = 1'b0; bRs = 10'd9; bExRs = 10'd9;
        #1;
        chk("nofwd_stall_ex", 32'(bStall), 32'h1);
        tick();
        chk("nofwd_stall_mem", 32'(bStall), 32'h1);
        chk("nofwd_sel_zero", 32'(bFwdSel), 32'h0);
        tick();
        chk("nofwd_stall_wb", 32'(bStall), 32'h1);
        tick();
        chk("nofwd_release", 32'(bStall), 32'h0);
        chk("nofwd_count3", 32'(bCount), 32'h3);
        bRd = 5'd9; bRegwrite = 1'b1; bRs = '0;
        tick();
        bRd = 5'd10; bRegwrite = 1'b0; bRs = {5'd9, 5'd0};
        #1;
        chk("nofwd_stall_rs2", 32'(bStall), 32'h1);
        tick();
        chk("sat_hold_4", 32'(bCount), 32'h3);
        tick();
        chk("sat_hold_5", 32'(bCount), 32'h3);
        bValid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
